column_drop_controller: RTL

- Consumer side of the native board column-select interface for the Connect-Four game.
- Takes the one-hot column_select produced while the player holds enter, validates the move, and animates the falling piece one row per step.
- Commits the piece to the board and hands the turn to the other player.
- Owns the board state and the current-player bit that drive the LED matrix display.

---
 rtl/column_drop_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/column_drop_controller.sv
// Connect-Four drop controller: validates one-hot column requests,
// animates the falling piece and commits it to the board.
module column_drop_controller #(
  parameter int ROWS       = 6,
  parameter int COLS       = 7,
  parameter int DROP_DELAY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COLS-1:0]      column_select,
  input  logic                 new_game,
  output logic [ROWS*COLS-1:0] board_red,
  output logic [ROWS*COLS-1:0] board_green,
  output logic                 player,
  output logic                 falling,
  output logic [2:0]           fall_row,
  output logic [2:0]           fall_col,
  output logic                 busy,
  output logic                 drop_done,
  output logic                 drop_reject,
  output logic                 board_full
);

  localparam int CELLS = ROWS * COLS;
  localparam int CW    = (DROP_DELAY > 1) ? $clog2(DROP_DELAY) : 1;
  localparam logic [CELLS-1:0] ONE = CELLS'(1);

  typedef enum logic [1:0] {
    IDLE,
    DROP,
    PLACE
  } state_e;

  state_e           state_q, state_d;
  logic [CELLS-1:0] red_q, red_d;
  logic [CELLS-1:0] green_q, green_d;
  logic             player_q, player_d;
  logic             reject_q, reject_d;
  logic             armed_q, armed_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CELLS-1:0] occ;
  logic [CELLS-1:0] cell_mask;
  logic [CELLS-1:0] below_mask;
  logic             below_occ;
  logic             req;
  logic             onehot;
  logic             top_busy;
  logic             last_step;
  logic             sel_any;
  logic [2:0]       sel_col;

  assign occ        = red_q | green_q;
  assign board_full = &occ[COLS-1:0];
  assign sel_any    = |column_select;
  assign onehot     = $onehot(column_select);
  assign top_busy   = |(occ[COLS-1:0] & column_select);
  assign req        = armed_q && sel_any;
  assign last_step  = (cnt_q == CW'(DROP_DELAY - 1));

  // Landing cell and the cell directly beneath the falling piece
  assign cell_mask  = ONE << (32'(row_q) * COLS + 32'(col_q));
  assign below_mask = ONE << ((32'(row_q) + 1) * COLS + 32'(col_q));
  assign below_occ  = |(occ & below_mask);

  always_comb begin
    sel_col = '0;
    for (int i = 0; i < COLS; i++) begin
      if (column_select[i]) sel_col = 3'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    red_d    = red_q;
    green_d  = green_q;
    player_d = player_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    armed_d  = armed_q | ~sel_any;

    if (new_game) begin
      state_d  = IDLE;
      red_d    = '0;
      green_d  = '0;
      player_d = 1'b0;
      row_d    = '0;
      col_d    = '0;
      cnt_d    = '0;
      // A request coinciding with new_game is consumed, not replayed
      if (sel_any) armed_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            armed_d = 1'b0;
            if (!onehot || top_busy || board_full) begin
              reject_d = 1'b1;
            end else begin
              state_d = DROP;
              col_d   = sel_col;
              row_d   = '0;
              cnt_d   = '0;
            end
          end
        end
        DROP: begin
          if (!last_step) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
            if (row_q == 3'(ROWS - 1) || below_occ) begin
              state_d = PLACE;
            end else begin
              row_d = row_q + 3'd1;
            end
          end
        end
        PLACE: begin
          state_d = IDLE;
          if (player_q) green_d = green_q | cell_mask;
          else          red_d   = red_q | cell_mask;
          player_d = ~player_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      red_q    <= '0;
      green_q  <= '0;
      player_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      reject_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      red_q    <= red_d;
      green_q  <= green_d;
      player_q <= player_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
      armed_q  <= armed_d;
    end
  end

  assign board_red   = red_q;
  assign board_green = green_q;
  assign player      = player_q;
  assign fall_row    = row_q;
  assign fall_col    = col_q;
  assign falling     = (state_q == DROP);
  assign busy        = (state_q == DROP) || (state_q == PLACE);
  assign drop_done   = (state_q == PLACE) && !new_game;
  assign drop_reject = reject_q && !new_game;

endmodule
